// File: rtl/div_16bit_restoring.sv
// -----------------------------------------------------------------------------
// div_16bit_restoring
//   Sequential radix-2 restoring divider. One quotient bit is resolved per clock
//   over DATA_WIDTH iterations, with a start/end handshake. It is the companion
//   to the 16-bit Wallace tree multiplier and shares its operand naming and its
//   result/flag style.
//
//   Optional feature macro: DIV_16BIT_SIGNED_EN
//     defined   : two's complement operands. Magnitudes are divided unsigned and
//                 the signs are fixed when the result is registered. The
//                 quotient truncates toward zero and the remainder takes the
//                 sign of the dividend. o_cry flags a quotient that does not
//                 fit the signed range.
//     undefined : unsigned operands, no sign logic, o_cry tied to 0.
//
// Ports
//   i_clk    in   1           clock, rising edge
//   i_rst    in   1           asynchronous active-high reset
//   i_start  in   1           division request, sampled only in IDLE
//   i_num_x  in   DATA_WIDTH  dividend, captured on the accepted start edge
//   i_num_y  in   DATA_WIDTH  divisor, captured on the accepted start edge
//   o_busy   out  1           high while iterating
//   o_end    out  1           one-cycle done pulse; results valid from here on
//   o_quo    out  DATA_WIDTH  quotient, held until the next result
//   o_rem    out  DATA_WIDTH  remainder, held until the next result
//   o_err    out  1           divide-by-zero flag
//   o_cry    out  1           signed quotient overflow flag
// -----------------------------------------------------------------------------
module div_16bit_restoring #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_num_x,
  input  logic [DATA_WIDTH-1:0] i_num_y,
  output logic                  o_busy,
  output logic                  o_end,
  output logic [DATA_WIDTH-1:0] o_quo,
  output logic [DATA_WIDTH-1:0] o_rem,
  output logic                  o_err,
  output logic                  o_cry
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt_p1;
  logic             accept;
  logic             div_zero;
  logic             last_iter;

  // Operand / working registers (data only, no reset needed)
  logic [W-1:0]     dvd_p1;   // dividend shifting out, quotient shifting in
  logic [W-1:0]     dvs_p1;   // divisor magnitude
  logic [W:0]       rem_p1;   // partial remainder

  // Iteration datapath
  logic [W+1:0]     shift_p0;
  logic [W+1:0]     diff_p0;
  logic             qbit_p0;
  logic [W:0]       rem_nxt_p0;
  logic [W-1:0]     quo_nxt_p0;

  // Final results after optional sign fix
  logic [W-1:0]     fin_quo;
  logic [W-1:0]     fin_rem;
  logic             fin_cry;

  logic [W-1:0]     cap_x;
  logic [W-1:0]     cap_y;

`ifdef DIV_16BIT_SIGNED_EN
  logic             neg_q_p1;
  logic             neg_r_p1;

  function automatic logic [W-1:0] neg_if(input logic neg, input logic [W-1:0] v);
    logic signed [W-1:0] sv;
    sv = v;
    return neg ? W'(-sv) : v;
  endfunction

  // A positive quotient overflows when its MSB is set; a negative one only when
  // its magnitude exceeds 2^(W-1).
  function automatic logic quo_overflow(input logic neg, input logic [W-1:0] mag);
    return neg ? (mag > {1'b1, {(W-1){1'b0}}}) : mag[W-1];
  endfunction

  assign cap_x   = neg_if(i_num_x[W-1], i_num_x);
  assign cap_y   = neg_if(i_num_y[W-1], i_num_y);
  assign fin_quo = neg_if(neg_q_p1, quo_nxt_p0);
  assign fin_rem = neg_if(neg_r_p1, rem_nxt_p0[W-1:0]);
  assign fin_cry = quo_overflow(neg_q_p1, quo_nxt_p0);
`else
  assign cap_x   = i_num_x;
  assign cap_y   = i_num_y;
  assign fin_quo = quo_nxt_p0;
  assign fin_rem = rem_nxt_p0[W-1:0];
  assign fin_cry = 1'b0;
`endif

  assign accept    = (state == S_IDLE) && i_start;
  assign div_zero  = (i_num_y == '0);
  assign last_iter = (state == S_CALC) && (cnt_p1 == CNT_LAST);

  assign o_busy = (state == S_CALC);
  assign o_end  = (state == S_DONE);

  // ---- FSM state register ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (i_start) state_nxt = div_zero ? S_DONE : S_CALC;
      S_CALC: if (cnt_p1 == CNT_LAST) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---- Iteration counter ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_p1 <= '0;
    end else if (accept) begin
      cnt_p1 <= '0;
    end else if (state == S_CALC) begin
      cnt_p1 <= cnt_p1 + 1'b1;
    end
  end

  // ---- Stage p0: shift, trial subtract, restore ----
  // The partial remainder never reaches the divisor, so the top bit of the
  // shifted value is always 0 and the difference MSB is the borrow.
  always_comb begin
    shift_p0 = {rem_p1, dvd_p1[W-1]};
    diff_p0  = shift_p0 - {2'b00, dvs_p1};
    qbit_p0  = ~diff_p0[W+1];
    if (qbit_p0) begin
      rem_nxt_p0 = diff_p0[W:0];
    end else begin
      rem_nxt_p0 = shift_p0[W:0];
    end
    quo_nxt_p0 = {dvd_p1[W-2:0], qbit_p0};
  end

  // ---- Stage p1: working registers ----
  always_ff @(posedge i_clk) begin
    if (accept) begin
      dvd_p1 <= cap_x;
      dvs_p1 <= cap_y;
      rem_p1 <= '0;
`ifdef DIV_16BIT_SIGNED_EN
      neg_q_p1 <= i_num_x[W-1] ^ i_num_y[W-1];
      neg_r_p1 <= i_num_x[W-1];
`endif
    end else if (state == S_CALC) begin
      dvd_p1 <= quo_nxt_p0;
      rem_p1 <= rem_nxt_p0;
    end
  end

  // ---- Result registers, loaded on the edge entering DONE ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_quo <= '0;
      o_rem <= '0;
      o_err <= 1'b0;
      o_cry <= 1'b0;
    end else if (accept && div_zero) begin
      o_quo <= '1;
      o_rem <= i_num_x;
      o_err <= 1'b1;
      o_cry <= 1'b0;
    end else if (last_iter) begin
      o_quo <= fin_quo;
      o_rem <= fin_rem;
      o_err <= 1'b0;
      o_cry <= fin_cry;
    end
  end

endmodule

// File: tb/tb_div_16bit_restoring.sv
// -----------------------------------------------------------------------------
// tb_div_16bit_restoring
//   Directed bench for div_16bit_restoring. Expected results come from a
//   behavioural model using native integer division, queued when a request is
//   launched and popped when o_end is observed.
// -----------------------------------------------------------------------------
module tb_div_16bit_restoring;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] num_x;
  logic [15:0] num_y;
  logic        busy;
  logic        done;
  logic [15:0] quo;
  logic [15:0] rem;
  logic        err;
  logic        cry;

  typedef struct packed {
    logic [15:0] quo;
    logic [15:0] rem;
    logic        err;
    logic        cry;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  div_16bit_restoring #(.DATA_WIDTH(16)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_num_x (num_x),
    .i_num_y (num_y),
    .o_busy  (busy),
    .o_end   (done),
    .o_quo   (quo),
    .o_rem   (rem),
    .o_err   (err),
    .o_cry   (cry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    int   q;
    int   r;
    if (y == 16'd0) begin
      e.quo = 16'hFFFF;
      e.rem = x;
      e.err = 1'b1;
      e.cry = 1'b0;
    end else begin
`ifdef DIV_16BIT_SIGNED_EN
      q = int'($signed(x)) / int'($signed(y));
      r = int'($signed(x)) % int'($signed(y));
      e.cry = (q > 32767) || (q < -32768);
`else
      q = int'(x) / int'(y);
      r = int'(x) % int'(y);
      e.cry = 1'b0;
`endif
      e.quo = q[15:0];
      e.rem = r[15:0];
      e.err = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Drive one request; returns just after the accepting edge.
  task automatic launch(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    num_x = x;
    num_y = y;
    start = 1'b1;
    sb.push_back(model(x, y));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Wait for o_end, checking latency, busy length, results and hold behaviour.
  task automatic await_result(input int exp_lat, input int exp_busy, input bit glitch);
    int   cycles;
    int   nbusy;
    bit   seen;
    exp_t e;
    cycles = 0;
    nbusy  = 0;
    seen   = 1'b0;
    while (!seen && cycles < 60) begin
      @(negedge clk);
      cycles++;
      if (busy) nbusy++;
      if (glitch && cycles == 5) begin
        num_x = 16'(($urandom));
        num_y = 16'($urandom_range(1, 65535));
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check("end_seen", 32'(seen), 32'd1);
    check("latency", 32'(cycles), 32'(exp_lat));
    check("busy_cycles", 32'(nbusy), 32'(exp_busy));
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("quo", 32'(quo), 32'(e.quo));
      check("rem", 32'(rem), 32'(e.rem));
      check("err", 32'(err), 32'(e.err));
      check("cry", 32'(cry), 32'(e.cry));
      @(negedge clk);
      check("end_pulse_width", 32'(done), 32'd0);
      check("hold_quo", 32'(quo), 32'(e.quo));
      check("hold_rem", 32'(rem), 32'(e.rem));
    end
  endtask

  task automatic run_div(input logic [15:0] x, input logic [15:0] y);
    launch(x, y);
    if (y == 16'd0) await_result(1, 0, 1'b0);
    else            await_result(17, 16, 1'b0);
  endtask

  initial begin
    int ends;
    rst   = 1'b1;
    start = 1'b0;
    num_x = '0;
    num_y = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_end", 32'(done), 32'd0);
    check("rst_quo", 32'(quo), 32'd0);
    check("rst_rem", 32'(rem), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cry", 32'(cry), 32'd0);
    rst = 1'b0;

    run_div(16'd100, 16'd7);
    run_div(16'h002A, 16'hFFF9);
    run_div(16'hFFFA, 16'h0005);
    run_div(16'h1234, 16'h0000);
    run_div(16'd9, 16'd3);
    run_div(16'h8000, 16'hFFFF);
    run_div(16'hFFFF, 16'h0001);
    run_div(16'h0005, 16'hFFFF);
    run_div(16'h0000, 16'h0013);
    for (int i = 0; i < 4; i++) begin
      run_div(16'($urandom), 16'($urandom_range(1, 65535)));
    end

    // Start pulse with new operands mid-calculation is ignored.
    launch(16'd1000, 16'd33);
    await_result(17, 16, 1'b1);

    // Reset mid-operation aborts with no done pulse.
    launch(16'hBEEF, 16'h0011);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_end", 32'(done), 32'd0);
    check("abort_quo", 32'(quo), 32'd0);
    check("abort_rem", 32'(rem), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    void'(sb.pop_front());
    @(negedge clk);
    rst  = 1'b0;
    ends = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ends++;
    end
    check("abort_no_end", 32'(ends), 32'd0);
    run_div(16'd9, 16'd3);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
